// File: rtl/shift_frame_ctrl_pkg.sv
// Shared definitions for the shift frame controller: FSM state encoding
// and a constant clog2 used to size the bit and divider counters.
package shift_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/shift_frame_sreg.sv
// WIDTH-bit frame shift register: parallel load, strobe-gated shift,
// serial in/out. Direction: MSB-first by default, LSB-first when
// SHIFT_FRAME_CTRL_LSB_FIRST_EN is defined.
module shift_frame_sreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ena,
  input  logic             sin,
  output logic             sout,
  output logic [WIDTH-1:0] data
);

  // Load has priority over shift; the controller never asserts both.
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end else if (ena) begin
`ifdef SHIFT_FRAME_CTRL_LSB_FIRST_EN
      data <= {sin, data[WIDTH-1:1]};
`else
      data <= {data[WIDTH-2:0], sin};
`endif
    end
  end

`ifdef SHIFT_FRAME_CTRL_LSB_FIRST_EN
  assign sout = data[0];
`else
  assign sout = data[WIDTH-1];
`endif

endmodule

// File: rtl/shift_frame_ctrl.sv
// Frame sequencer for a serial shift datapath: accepts a parallel word
// over valid/ready, shifts it out at one bit per DIV cycles while
// shifting sin in, then presents the received word with a valid pulse.
// Bit order follows SHIFT_FRAME_CTRL_LSB_FIRST_EN (see shift_frame_sreg).
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | waiting for tx_valid; tx_ready high, sout low
// ST_SHIFT | shifting; one shift_ena strobe every DIV cycles
// ST_DONE  | single cycle; received word captured on exit
module shift_frame_ctrl
  import shift_frame_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic             sin,
  output logic             sout,
  output logic             shift_ena,
  output logic             busy,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid
);

  localparam int BIT_W = clog2(WIDTH);
  localparam int DIV_W = (DIV > 1) ? clog2(DIV) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  state_t             state_q;
  state_t             state_d;
  logic [BIT_W-1:0]   bit_cnt;
  logic [DIV_W-1:0]   div_cnt;
  logic               load;
  logic               sreg_sout;
  logic [WIDTH-1:0]   sreg;

  shift_frame_sreg #(.WIDTH(WIDTH)) u_sreg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (tx_data),
    .ena       (shift_ena),
    .sin       (sin),
    .sout      (sreg_sout),
    .data      (sreg)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state, handshake and strobe decode; unused encoding behaves as idle.
  always_comb begin
    state_d   = state_q;
    tx_ready  = 1'b0;
    busy      = 1'b0;
    load      = 1'b0;
    shift_ena = 1'b0;
    sout      = 1'b0;
    case (state_q)
      ST_SHIFT: begin
        busy = 1'b1;
        sout = sreg_sout;
        if (div_cnt == DIV_LAST) begin
          shift_ena = 1'b1;
          if (bit_cnt == BIT_LAST) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          load    = 1'b1;
          state_d = ST_SHIFT;
        end
      end
    endcase
  end

  // Bit-period divider and bit counter; both wrap at their terminal value.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (state_q == ST_SHIFT) begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      if (shift_ena) bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    end
  end

  // Capture the received word when leaving DONE and pulse rx_valid once.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= (state_q == ST_DONE);
      if (state_q == ST_DONE) rx_data <= sreg;
    end
  end

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Directed bench for shift_frame_ctrl: a DIV=4 instance with sin looped
// back to sout and a DIV=1 instance with sin driven from the bench.
module tb_shift_frame_ctrl;

  localparam int WIDTH = 8;
`ifdef SHIFT_FRAME_CTRL_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DIV=4 instance, loopback
  logic             rst_a, tx_valid_a;
  logic [WIDTH-1:0] tx_data_a;
  logic             tx_ready_a, sin_a, sout_a, shift_ena_a, busy_a, rx_valid_a;
  logic [WIDTH-1:0] rx_data_a;
  assign sin_a = sout_a;

  // DIV=1 instance, driven sin
  logic             rst_b, tx_valid_b, sin_b;
  logic [WIDTH-1:0] tx_data_b;
  logic             tx_ready_b, sout_b, shift_ena_b, busy_b, rx_valid_b;
  logic [WIDTH-1:0] rx_data_b;

  shift_frame_ctrl #(.WIDTH(WIDTH), .DIV(4)) u_dut_a (
    .clk(clk), .rst(rst_a), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready_a), .sin(sin_a), .sout(sout_a), .shift_ena(shift_ena_a),
    .busy(busy_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a)
  );

  shift_frame_ctrl #(.WIDTH(WIDTH), .DIV(1)) u_dut_b (
    .clk(clk), .rst(rst_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .sin(sin_b), .sout(sout_b), .shift_ena(shift_ena_b),
    .busy(busy_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int bit_idx(input int c, input int div);
    int k;
    k = (c - 1) / div;
    return LSB_FIRST ? k : WIDTH - 1 - k;
  endfunction

  logic [63:0] ena_v, rdy_v, rxv_v, busy_v;
  logic [63:0] exp_ena4, exp_rdy4, exp_rxv4, exp_busy4;
  int          sout_err;
  logic        sout_first;

  // One DIV=4 loopback frame starting in the current (ready) cycle 0.
  task automatic run_a(input logic [WIDTH-1:0] word, input int ncyc,
                       input bit hold, input logic [WIDTH-1:0] next_word);
    tx_data_a  = word;
    tx_valid_a = 1'b1;
    ena_v = '0; rdy_v = '0; rxv_v = '0; busy_v = '0;
    sout_err = 0;
    for (int c = 1; c <= ncyc; c++) begin
      step();
      if (c == 1) begin
        if (hold) tx_data_a = next_word;
        else      tx_valid_a = 1'b0;
        sout_first = sout_a;
      end
      ena_v[c]  = shift_ena_a;
      rdy_v[c]  = tx_ready_a;
      rxv_v[c]  = rx_valid_a;
      busy_v[c] = busy_a;
      if (c <= WIDTH * 4 && sout_a !== word[bit_idx(c, 4)]) sout_err++;
    end
  endtask

  initial begin
    logic [WIDTH-1:0] seq;
    logic [WIDTH-1:0] exp_rx_b;
    logic [15:0]      ena_b, rdy_b;
    int               sout_err_b, rx_pulses, busy_rises, busy_seen;
    logic             busy_prev;

    exp_ena4 = '0;
    for (int k = 1; k <= WIDTH; k++) exp_ena4[4*k] = 1'b1;
    exp_rdy4  = 64'd1 << 34;
    exp_rxv4  = 64'd1 << 34;
    exp_busy4 = ((64'd1 << 34) - 1) & ~64'd1;

    rst_a = 1'b1; tx_valid_a = 1'b0; tx_data_a = '0;
    rst_b = 1'b1; tx_valid_b = 1'b0; tx_data_b = '0; sin_b = 1'b0;
    repeat (3) step();

    // reset values
    check("rst_tx_ready", {63'd0, tx_ready_a}, 64'd1);
    check("rst_busy", {63'd0, busy_a}, 64'd0);
    check("rst_sout", {63'd0, sout_a}, 64'd0);
    check("rst_shift_ena", {63'd0, shift_ena_a}, 64'd0);
    check("rst_rx", {55'd0, rx_valid_a, rx_data_a}, 64'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // loopback 0xA5, DIV=4
    run_a(8'hA5, 34, 1'b0, 8'h00);
    check("a5_shift_ena", ena_v, exp_ena4);
    check("a5_tx_ready", rdy_v, exp_rdy4);
    check("a5_rx_valid", rxv_v, exp_rxv4);
    check("a5_busy", busy_v, exp_busy4);
    check("a5_sout_errs", 64'(sout_err), 64'd0);
    check("a5_rx_data", {56'd0, rx_data_a}, 64'hA5);

    // tx_valid held: 0x01 then 0xFF back to back
    run_a(8'h01, 34, 1'b1, 8'hFF);
    check("hold1_tx_ready", rdy_v, exp_rdy4);
    check("hold1_rx_valid", rxv_v, exp_rxv4);
    check("hold1_rx_data", {56'd0, rx_data_a}, 64'h01);
    run_a(8'hFF, 34, 1'b0, 8'h00);
    check("hold2_busy", busy_v, exp_busy4);
    check("hold2_rx_valid", rxv_v, exp_rxv4);
    check("hold2_rx_data", {56'd0, rx_data_a}, 64'hFF);

    // reset at cycle 13 of a frame
    tx_data_a = 8'h3C; tx_valid_a = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      step();
      tx_valid_a = 1'b0;
    end
    check("mid_busy_before", {63'd0, busy_a}, 64'd1);
    check("mid_rx_hold", {56'd0, rx_data_a}, 64'hFF);
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    check("mid_rst_outs", {60'd0, busy_a, sout_a, tx_ready_a, shift_ena_a}, 64'b0010);
    check("mid_rst_rx", {55'd0, rx_valid_a, rx_data_a}, 64'd0);
    rx_pulses = 0; busy_seen = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (rx_valid_a) rx_pulses++;
      if (busy_a) busy_seen++;
    end
    check("mid_no_rx_valid", 64'(rx_pulses), 64'd0);
    check("mid_stays_idle", 64'(busy_seen), 64'd0);

    // tx_valid pulses during SHIFT/DONE are ignored
    tx_data_a = 8'h5A; tx_valid_a = 1'b1;
    rx_pulses = 0; busy_rises = 0; busy_prev = busy_a;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (c == 1 || c == 11 || c == 34) tx_valid_a = 1'b0;
      if (c == 10 || c == 33) begin
        tx_valid_a = 1'b1;
        tx_data_a  = 8'h99;
      end
      if (rx_valid_a) rx_pulses++;
      if (busy_a && !busy_prev) busy_rises++;
      busy_prev = busy_a;
    end
    check("ign_frames", 64'(busy_rises), 64'd1);
    check("ign_rx_pulses", 64'(rx_pulses), 64'd1);
    check("ign_rx_data", {56'd0, rx_data_a}, 64'h5A);

    // 0x81 then 0x02 loopback; first serial bit 1 then 0 either order
    run_a(8'h81, 34, 1'b0, 8'h00);
    check("x81_first_bit", {63'd0, sout_first}, 64'd1);
    check("x81_sout_errs", 64'(sout_err), 64'd0);
    check("x81_rx_data", {56'd0, rx_data_a}, 64'h81);
    run_a(8'h02, 34, 1'b0, 8'h00);
    check("x02_first_bit", {63'd0, sout_first}, 64'd0);
    check("x02_rx_data", {56'd0, rx_data_a}, 64'h02);

    // DIV=1: tx 0x3C, sin 1,1,0,0,1,0,1,0 on successive strobes
    seq      = 8'b1100_1010;
    exp_rx_b = LSB_FIRST ? 8'h53 : 8'hCA;
    tx_data_b = 8'h3C; tx_valid_b = 1'b1;
    ena_b = '0; rdy_b = '0; sout_err_b = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      tx_valid_b = 1'b0;
      sin_b = (c <= 8) ? seq[8-c] : 1'b0;
      ena_b[c] = shift_ena_b;
      rdy_b[c] = tx_ready_b;
      if (c <= 8 && sout_b !== tx_data_b[bit_idx(c, 1)]) sout_err_b++;
      if (c == 10) check("div1_rx_valid", {63'd0, rx_valid_b}, 64'd1);
    end
    check("div1_shift_ena", {48'd0, ena_b}, 64'h01FE);
    check("div1_tx_ready", {48'd0, rdy_b}, 64'h0400);
    check("div1_sout_errs", 64'(sout_err_b), 64'd0);
    check("div1_rx_data", {56'd0, rx_data_b}, {56'd0, exp_rx_b});
    step();
    check("div1_rx_valid_once", {63'd0, rx_valid_b}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
